// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets N_REQ byte sources share one UART transmit port.
// A grant lasts for a burst and only one byte is ever outstanding at the UART.
module uart_tx_arb #(
    parameter int  N_REQ     = 4,
    parameter int  DW        = 8,
    parameter int  MAX_BURST = 16,
    localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       uart_tx_data,
    output logic                uart_tx_req,
    input  logic                uart_tx_busy,
    output logic                grant_valid,
    output logic [IW-1:0]       grant_id,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACC  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   w_grant_id_nxt;
    logic            r_grant_valid;
    logic            w_grant_valid_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_rr_ptr_nxt;
    logic [7:0]      r_burst_cnt;
    logic [7:0]      w_burst_cnt_nxt;
    logic            r_last_flag;
    logic            w_last_flag_nxt;
    logic [DW-1:0]   r_tx_data;
    logic [DW-1:0]   w_tx_data_nxt;
    logic            r_tx_req;
    logic            w_tx_req_nxt;

    logic            w_any;
    logic [IW-1:0]   w_winner;
    int              w_idx;
    logic            w_sel_valid;
    logic [DW-1:0]   w_sel_data;
    logic            w_sel_last;
    logic            w_hs;
    logic            w_burst_full;
    logic [N_REQ-1:0] w_ready;

    // Rotating search starting just after the last released requester.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = IW'(w_idx);
            end
        end
    end

    assign w_sel_valid  = req_valid[r_grant_id];
    assign w_sel_data   = req_data[r_grant_id*DW +: DW];
    assign w_sel_last   = req_last[r_grant_id];
    assign w_burst_full = (r_burst_cnt == 8'(MAX_BURST));

    // A byte moves when req_valid and req_ready are both high at a rising edge;
    // ready is offered only to the owner, only in ISSUE, and only while the UART is idle.
    assign w_hs = (r_state == ISSUE) && w_sel_valid && !uart_tx_busy;

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_burst_cnt_nxt   = r_burst_cnt;
        w_last_flag_nxt   = r_last_flag;
        w_tx_data_nxt     = r_tx_data;
        w_tx_req_nxt      = 1'b0;
        w_ready           = '0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_id_nxt    = w_winner;
                    w_grant_valid_nxt = 1'b1;
                    w_burst_cnt_nxt   = '0;
                    w_state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                w_ready[r_grant_id] = w_sel_valid && !uart_tx_busy;
                if (w_hs) begin
                    w_tx_data_nxt   = w_sel_data;
                    w_tx_req_nxt    = 1'b1;
                    w_last_flag_nxt = w_sel_last;
                    w_burst_cnt_nxt = w_burst_full ? r_burst_cnt : r_burst_cnt + 8'd1;
                    w_state_nxt     = WAIT_ACC;
                end else if (!w_sel_valid) begin
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = r_grant_id;
                    w_state_nxt       = IDLE;
                end
            end
            WAIT_ACC: begin
                if (uart_tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (r_last_flag || w_burst_full) begin
                        w_grant_valid_nxt = 1'b0;
                        w_rr_ptr_nxt      = r_grant_id;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= IW'(N_REQ - 1);
            r_burst_cnt   <= '0;
            r_last_flag   <= 1'b0;
            r_tx_data     <= '0;
            r_tx_req      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_burst_cnt   <= w_burst_cnt_nxt;
            r_last_flag   <= w_last_flag_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_req      <= w_tx_req_nxt;
        end
    end

    // Ready is combinational, so it is masked while reset is held.
    assign req_ready    = w_ready & {N_REQ{resetn}};
    assign uart_tx_data = r_tx_data;
    assign uart_tx_req  = r_tx_req;
    assign grant_valid  = r_grant_valid;
    assign grant_id     = r_grant_id;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: arbitration table, then multi-byte burst sequences
// checked against an expected queue of {grant_id, byte} at every UART start pulse.
module tb_uart_tx_arb;

    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int MB       = 4;
    localparam int IW       = 2;
    localparam int W        = IW + DW;
    localparam int BUSY_LEN = 10;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   uart_tx_data;
    logic            uart_tx_req;
    logic            uart_tx_busy;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;
    logic [1:0]      dbg_state;

    uart_tx_arb #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_data (uart_tx_data),
        .uart_tx_req  (uart_tx_req),
        .uart_tx_busy (uart_tx_busy),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // UART model: busy rises the cycle after a start pulse and lasts BUSY_LEN cycles.
    int   busy_cnt = 0;
    logic ext_busy = 1'b0;
    always @(posedge clk) begin
        if (uart_tx_req) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_tx_busy = (busy_cnt != 0) || ext_busy;

    // Requester sources, scoreboard and counters
    logic [DW:0]   src_q[N][$];
    logic [W-1:0]  exp_q[$];
    logic [N-1:0]  en = '0;
    logic [N-1:0]  hs = '0;
    logic          manual = 1'b0;
    logic [N-1:0]  manual_valid = '0;
    logic          rstn_req = 1'b0;
    logic          ext_busy_req = 1'b0;
    logic          prev_req = 1'b0;
    int            rdy_cnt[N];
    int            pop_cnt[N];
    int            checks = 0;
    int            failures = 0;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic          exp_gv;
        logic [IW-1:0] exp_gid;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic src_push(input int r, input logic [DW-1:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic expect_byte(input int id, input logic [DW-1:0] d);
        exp_q.push_back({IW'(id), d});
    endtask

    // One cycle: retire last cycle's handshakes, monitor, drive, sample ready.
    task automatic step();
        logic [DW:0]  h;
        logic [W-1:0] e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                h = src_q[i].pop_front();
                pop_cnt[i]++;
            end
        end
        if (uart_tx_req) begin
            chk("tx_pulse_width", 32'(prev_req), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected: got id=%0d data=0x%0h expected no transfer", grant_id, uart_tx_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, uart_tx_data} !== e) begin
                    failures++;
                    $display("FAIL tx_id_data: got id=%0d data=0x%0h expected id=%0d data=0x%0h",
                             grant_id, uart_tx_data, e[W-1:DW], e[DW-1:0]);
                end
            end
        end
        prev_req = uart_tx_req;
        resetn   = rstn_req;
        ext_busy = ext_busy_req;
        for (int i = 0; i < N; i++) begin
            if (manual) begin
                req_valid[i]          = manual_valid[i];
                req_data[i*DW +: DW]  = DW'($urandom_range(0, 255));
                req_last[i]           = 1'b0;
            end else if (en[i] && src_q[i].size() > 0) begin
                h                     = src_q[i][0];
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = h[DW-1:0];
                req_last[i]           = h[DW];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = DW'($urandom_range(0, 255));
                req_last[i]           = 1'($urandom_range(0, 1));
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            hs[i] = req_valid[i] & req_ready[i];
            rdy_cnt[i] += int'(req_ready[i]);
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && grant_valid == 1'b0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles, got %0d bytes outstanding expected 0", name, n, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rstn_req = 1'b0;
        step();
        step();
        rstn_req = 1'b1;
        step();
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            rdy_cnt[i] = 0;
            pop_cnt[i] = 0;
        end
        tbl[0]  = '{mask: 4'b0000, exp_gv: 1'b0, exp_gid: 2'd0};
        tbl[1]  = '{mask: 4'b1111, exp_gv: 1'b1, exp_gid: 2'd0};
        tbl[2]  = '{mask: 4'b1111, exp_gv: 1'b1, exp_gid: 2'd1};
        tbl[3]  = '{mask: 4'b1111, exp_gv: 1'b1, exp_gid: 2'd2};
        tbl[4]  = '{mask: 4'b1111, exp_gv: 1'b1, exp_gid: 2'd3};
        tbl[5]  = '{mask: 4'b0110, exp_gv: 1'b1, exp_gid: 2'd1};
        tbl[6]  = '{mask: 4'b0110, exp_gv: 1'b1, exp_gid: 2'd2};
        tbl[7]  = '{mask: 4'b0110, exp_gv: 1'b1, exp_gid: 2'd1};
        tbl[8]  = '{mask: 4'b1000, exp_gv: 1'b1, exp_gid: 2'd3};
        tbl[9]  = '{mask: 4'b0001, exp_gv: 1'b1, exp_gid: 2'd0};
        tbl[10] = '{mask: 4'b0001, exp_gv: 1'b1, exp_gid: 2'd0};
        tbl[11] = '{mask: 4'b1001, exp_gv: 1'b1, exp_gid: 2'd3};

        // Reset with every requester asserting valid
        manual       = 1'b1;
        manual_valid = 4'b1111;
        rstn_req     = 1'b0;
        step();
        step();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_grant_valid", 32'(grant_valid), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_tx_req", 32'(uart_tx_req), 32'd0);
        chk("reset_tx_data", 32'(uart_tx_data), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        manual_valid = '0;
        rstn_req     = 1'b1;
        step();

        // Arbitration table, UART held busy so only grants move
        ext_busy_req = 1'b1;
        for (int v = 0; v < 12; v++) begin
            manual_valid = tbl[v].mask;
            step();
            step();
            chk($sformatf("tbl%0d_grant_valid", v), 32'(grant_valid), 32'(tbl[v].exp_gv));
            if (tbl[v].exp_gv) chk($sformatf("tbl%0d_grant_id", v), 32'(grant_id), 32'(tbl[v].exp_gid));
            chk($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'd0);
            manual_valid = '0;
            step();
            step();
            chk($sformatf("tbl%0d_release", v), 32'(grant_valid), 32'd0);
        end
        manual       = 1'b0;
        ext_busy_req = 1'b0;
        step();

        // Three-byte packet from requester 0
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        src_push(0, 8'h11, 1'b0);
        src_push(0, 8'h22, 1'b0);
        src_push(0, 8'h33, 1'b1);
        expect_byte(0, 8'h11);
        expect_byte(0, 8'h22);
        expect_byte(0, 8'h33);
        en = 4'b0001;
        run_until_idle("t1_packet", 300);
        chk("t1_busy_at_release", 32'(uart_tx_busy), 32'd0);
        chk("t1_ready_cycles", 32'(rdy_cnt[0]), 32'd3);

        // Two packets contending from reset: no interleaving
        do_reset();
        src_push(1, 8'hA1, 1'b0);
        src_push(1, 8'hA2, 1'b1);
        src_push(2, 8'hB1, 1'b0);
        src_push(2, 8'hB2, 1'b1);
        expect_byte(1, 8'hA1);
        expect_byte(1, 8'hA2);
        expect_byte(2, 8'hB1);
        expect_byte(2, 8'hB2);
        en = 4'b1111;
        run_until_idle("t2_two_packets", 300);

        // Burst limit: requester 3 streams 10 bytes, requester 0 cuts in
        for (int k = 1; k <= 10; k++) src_push(3, DW'(8'h30 + k), 1'b0);
        src_push(0, 8'h01, 1'b0);
        src_push(0, 8'h02, 1'b1);
        for (int k = 1; k <= 4; k++) expect_byte(3, DW'(8'h30 + k));
        expect_byte(0, 8'h01);
        expect_byte(0, 8'h02);
        for (int k = 5; k <= 10; k++) expect_byte(3, DW'(8'h30 + k));
        run_until_idle("t3_burst_limit", 600);

        // Requester 0 drops valid after two of five bytes
        for (int k = 1; k <= 5; k++) src_push(0, DW'(8'hC0 + k), k == 5);
        src_push(2, 8'hD1, 1'b0);
        src_push(2, 8'hD2, 1'b1);
        expect_byte(0, 8'hC1);
        expect_byte(0, 8'hC2);
        expect_byte(2, 8'hD1);
        expect_byte(2, 8'hD2);
        n = pop_cnt[0];
        begin
            int c;
            c = 0;
            while (!(exp_q.size() == 0 && grant_valid == 1'b0) && c < 300) begin
                step();
                if (pop_cnt[0] == n + 2) en[0] = 1'b0;
                c++;
            end
            checks++;
            if (c >= 300) begin
                failures++;
                $display("FAIL t4_drop_valid: timeout, got %0d bytes outstanding expected 0", exp_q.size());
            end
        end
        chk("t4_held_bytes", 32'(src_q[0].size()), 32'd3);
        en[0] = 1'b1;
        expect_byte(0, 8'hC3);
        expect_byte(0, 8'hC4);
        expect_byte(0, 8'hC5);
        run_until_idle("t4_resume", 300);

        // Reset pulse during WAIT_DONE of the second byte
        src_push(1, 8'hE1, 1'b0);
        src_push(1, 8'hE2, 1'b0);
        src_push(1, 8'hE3, 1'b1);
        expect_byte(1, 8'hE1);
        expect_byte(1, 8'hE2);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("t5_second_byte_seen", 32'(exp_q.size()), 32'd0);
        step();
        step();
        chk("t5_in_wait_done", 32'(dbg_state), 32'd3);
        src_push(0, 8'hF1, 1'b1);
        rstn_req = 1'b0;
        step();
        chk("t5_reset_cycle_ready", 32'(req_ready), 32'd0);
        rstn_req = 1'b1;
        step();
        chk("t5_grant_valid", 32'(grant_valid), 32'd0);
        chk("t5_grant_id", 32'(grant_id), 32'd0);
        chk("t5_tx_req", 32'(uart_tx_req), 32'd0);
        chk("t5_tx_data", 32'(uart_tx_data), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'd0);
        expect_byte(0, 8'hF1);
        expect_byte(1, 8'hE3);
        run_until_idle("t5_after_reset", 300);

        // UART busy from elsewhere for 20 cycles on grant entry
        ext_busy_req = 1'b1;
        src_push(2, 8'h5A, 1'b1);
        expect_byte(2, 8'h5A);
        step();
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("t6_ready_c%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("t6_tx_req_c%0d", k), 32'(uart_tx_req), 32'd0);
        end
        chk("t6_grant_valid", 32'(grant_valid), 32'd1);
        chk("t6_grant_id", 32'(grant_id), 32'd2);
        ext_busy_req = 1'b0;
        step();
        chk("t6_ready_after_busy", 32'(req_ready), 32'h4);
        step();
        chk("t6_tx_req_after_busy", 32'(uart_tx_req), 32'd1);
        run_until_idle("t6_finish", 200);

        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
